// File: rtl/fp_multiplier_if.sv
// Start/busy/valid/out_reg handshake shared by the FP multiplier and divider.
interface fp_multiplier_if #(
  parameter int unsigned width = 32
);
  logic             start;
  logic [width-1:0] multiplicand;
  logic [width-1:0] multiplier;
  logic             busy;
  logic             valid;
  logic [width-1:0] out_reg;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, valid, out_reg
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, valid, out_reg
  );
endinterface

// File: rtl/fp_multiplier.sv
// Sequential IEEE-754 single-precision multiplier (24-step shift-and-add).
// Optional round-to-nearest-even in NORMALIZE: define FP_MUL_ROUND_NEAREST_EN.
// Without it, results are truncated toward zero.
module fp_multiplier #(
  parameter int unsigned width = 32,
  parameter int unsigned ITER  = 24
) (
  input  logic           clk,
  input  logic           rst,
  fp_multiplier_if.slave bus
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned PROD_W = 48;
  localparam int unsigned EXP_W  = 10;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] COMPUTE   = 2'd1;
  localparam logic [1:0] NORMALIZE = 2'd2;
  localparam logic [1:0] FINAL     = 2'd3;

  logic [1:0]              state;
  logic [1:0]              next_state;
  logic                    sign;
  logic [MANT_W-1:0]       mcand;
  logic [MANT_W-1:0]       mplr;
  logic [PROD_W-1:0]       product;
  logic [CNT_W-1:0]        counter;
  logic signed [EXP_W-1:0] exp_sum;
  logic signed [EXP_W-1:0] exp_r;
  logic [22:0]             frac_r;

  logic [7:0]              exp_a_c;
  logic [7:0]              exp_b_c;
  logic [22:0]             frac_a_c;
  logic [22:0]             frac_b_c;
  logic                    sign_c;
  logic                    special_c;
  logic [width-1:0]        special_res_c;
  logic [22:0]             frac_n_c;
  logic signed [EXP_W-1:0] exp_n_c;

  assign exp_a_c  = bus.multiplicand[30:23];
  assign exp_b_c  = bus.multiplier[30:23];
  assign frac_a_c = bus.multiplicand[22:0];
  assign frac_b_c = bus.multiplier[22:0];
  assign sign_c   = bus.multiplicand[31] ^ bus.multiplier[31];

  // Classify operands: NaN, inf*0, inf, zero/subnormal, in priority order
  always_comb begin
    special_c     = 1'b1;
    special_res_c = '0;
    if ((exp_a_c == 8'hFF && frac_a_c != 23'h0) || (exp_b_c == 8'hFF && frac_b_c != 23'h0)) begin
      special_res_c = width'(32'h7FC00000);
    end else if ((exp_a_c == 8'hFF && exp_b_c == 8'h00) || (exp_b_c == 8'hFF && exp_a_c == 8'h00)) begin
      special_res_c = width'(32'h7FC00000);
    end else if (exp_a_c == 8'hFF || exp_b_c == 8'hFF) begin
      special_res_c = width'({sign_c, 8'hFF, 23'h0});
    end else if (exp_a_c == 8'h00 || exp_b_c == 8'h00) begin
      special_res_c = width'({sign_c, 31'h0});
    end else begin
      special_c = 1'b0;
    end
  end

`ifdef FP_MUL_ROUND_NEAREST_EN
  logic              guard_c;
  logic              sticky_c;
  logic              round_up_c;
  logic              carry_c;
  logic [22:0]       frac_rnd_c;
`endif

  // Pick the fraction window from the product's leading one; optionally round
  always_comb begin
    frac_n_c = product[45:23];
    exp_n_c  = exp_sum;
    if (product[47]) begin
      frac_n_c = product[46:24];
      exp_n_c  = exp_sum + 10'sd1;
    end
`ifdef FP_MUL_ROUND_NEAREST_EN
    guard_c    = product[47] ? product[23] : product[22];
    sticky_c   = product[47] ? (|product[22:0]) : (|product[21:0]);
    round_up_c = guard_c & (sticky_c | frac_n_c[0]);
    {carry_c, frac_rnd_c} = {1'b0, frac_n_c} + 24'(round_up_c);
    frac_n_c = frac_rnd_c;
    if (carry_c) begin
      exp_n_c = exp_n_c + 10'sd1;
    end
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; special cases never leave IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (bus.start && !special_c) next_state = COMPUTE;
      COMPUTE:   if (counter == CNT_W'(ITER - 1)) next_state = NORMALIZE;
      NORMALIZE: next_state = FINAL;
      FINAL:     next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.busy    <= 1'b0;
      bus.valid   <= 1'b0;
      bus.out_reg <= '0;
      sign        <= 1'b0;
      mcand       <= '0;
      mplr        <= '0;
      product     <= '0;
      counter     <= '0;
      exp_sum     <= '0;
      exp_r       <= '0;
      frac_r      <= '0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign <= sign_c;
            if (special_c) begin
              bus.out_reg <= special_res_c;
              bus.valid   <= 1'b1;
            end else begin
              mcand    <= {1'b1, frac_a_c};
              mplr     <= {1'b1, frac_b_c};
              product  <= '0;
              exp_sum  <= EXP_W'(exp_a_c) + EXP_W'(exp_b_c) - 10'sd127;
              counter  <= '0;
              bus.busy <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (mplr[0]) begin
            product <= product + (PROD_W'(mcand) << counter);
          end
          mplr    <= mplr >> 1;
          counter <= counter + CNT_W'(1);
        end
        NORMALIZE: begin
          frac_r <= frac_n_c;
          exp_r  <= exp_n_c;
        end
        FINAL: begin
          if (exp_r >= 10'sd255) begin
            bus.out_reg <= width'({sign, 8'hFF, 23'h0});
          end else if (exp_r <= 10'sd0) begin
            bus.out_reg <= width'({sign, 31'h0});
          end else begin
            bus.out_reg <= width'({sign, exp_r[7:0], frac_r});
          end
          bus.valid <= 1'b1;
          bus.busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_multiplier.sv
// Self-checking bench for fp_multiplier: transaction-level reference model
// plus directed cases with literal expectations and randomized traffic.
module tb_fp_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fp_multiplier_if #(.width(32)) bus ();

  fp_multiplier #(.width(32), .ITER(24)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // IEEE single multiply under the block's rules (flush subnormals, no subnormal output)
  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            output bit special);
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        s;
    longint unsigned p, m, rem, half;
    int e, sh;
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0];  fb = b[22:0];
    s  = a[31] ^ b[31];
    special = (ea == 8'h00) || (ea == 8'hFF) || (eb == 8'h00) || (eb == 8'hFF);
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0)) return 32'h7FC00000;
    if ((ea == 8'hFF && eb == 8'h00) || (eb == 8'hFF && ea == 8'h00)) return 32'h7FC00000;
    if (ea == 8'hFF || eb == 8'hFF) return {s, 8'hFF, 23'h0};
    if (ea == 8'h00 || eb == 8'h00) return {s, 31'h0};
    p    = 64'({1'b1, fa}) * 64'({1'b1, fb});
    sh   = (p >= 64'h8000_0000_0000) ? 24 : 23;
    e    = int'(ea) + int'(eb) - 127 + (sh - 23);
    m    = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
`ifdef FP_MUL_ROUND_NEAREST_EN
    if (rem > half || (rem == half && m[0])) m = m + 64'd1;
    if (m == (64'd1 << 24)) begin
      m = 64'd1 << 23;
      e = e + 1;
    end
`else
    if (rem > half) m = m; // truncation: remainder discarded
`endif
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, 8'(e), 23'(m)};
  endfunction

  // Operand generator biased toward the interesting exponent classes
  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    int k;
    k = $urandom_range(0, 11);
    f = 23'($urandom);
    case (k)
      0: begin e = 8'h00; if ($urandom_range(0, 1) == 0) f = '0; end
      1: begin e = 8'hFF; if ($urandom_range(0, 2) != 0) f = '0; end
      2: e = 8'($urandom_range(1, 15));
      3: e = 8'($urandom_range(235, 254));
      default: e = 8'($urandom_range(96, 160));
    endcase
    if ($urandom_range(0, 3) == 0) f[11:0] = '0;
    return {1'($urandom), e, f};
  endfunction

  // Reference timing: normal result lands 26 edges after the accepting edge,
  // special result lands on the accepting edge; starts while pending are dropped
  int          m_cnt   = 0;
  logic        m_busy  = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_out   = '0;
  logic [31:0] m_pend  = '0;

  always @(posedge clk or posedge rst) begin
    logic [31:0] r;
    bit sp;
    if (rst) begin
      m_cnt = 0; m_busy = 1'b0; m_valid = 1'b0; m_out = '0;
    end else begin
      m_valid = 1'b0;
      if (m_cnt != 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_valid = 1'b1; m_busy = 1'b0; m_out = m_pend;
        end
      end else if (bus.start) begin
        r = mul_model(bus.multiplicand, bus.multiplier, sp);
        if (sp) begin
          m_valid = 1'b1; m_out = r;
        end else begin
          m_cnt = 26; m_busy = 1'b1; m_pend = r;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    check("valid", 32'(bus.valid), 32'(m_valid));
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("out_reg", bus.out_reg, m_out);
    if (bus.valid && bus.busy) check("valid_and_busy", 32'd1, 32'd0);
  end

  // One operation; edges = index of the edge after which valid is seen (start edge = 0)
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int edges, output logic [31:0] res, output bit seen_busy);
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = a; bus.multiplier = b;
    @(negedge clk);
    bus.start = 1'b0; bus.multiplicand = $urandom; bus.multiplier = $urandom;
    edges = 0; seen_busy = 1'b0;
    while (!bus.valid && edges < 40) begin
      seen_busy |= bus.busy;
      @(negedge clk);
      edges++;
    end
    res = bus.out_reg;
  endtask

  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_edges);
    int e; logic [31:0] r; bit sb, sp;
    check({name, "_model"}, mul_model(a, b, sp), exp);
    run_op(a, b, e, r, sb);
    check({name, "_result"}, r, exp);
    check({name, "_latency"}, 32'(e), 32'(exp_edges));
    check({name, "_busy_seen"}, 32'(sb), (exp_edges == 0) ? 32'd0 : 32'd1);
  endtask

  initial begin
    int vcount;
    bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_valid", 32'(bus.valid), 32'd0);
    check("reset_out", bus.out_reg, 32'd0);
    rst = 1'b0;

    directed("mul_2x3",     32'h40000000, 32'h40400000, 32'h40C00000, 26);
    directed("mul_m2xhalf", 32'hC0000000, 32'h3F000000, 32'hBF800000, 26);
    directed("mul_1p5sq",   32'h3FC00000, 32'h3FC00000, 32'h40100000, 26);
    directed("overflow",    32'h7F000000, 32'h40000000, 32'h7F800000, 26);
    directed("underflow",   32'h00800000, 32'h00800000, 32'h00000000, 26);
    directed("inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 0);
    directed("ninf_x_2",    32'hFF800000, 32'h40000000, 32'hFF800000, 0);
    directed("nzero_x_1",   32'h80000000, 32'h3F800000, 32'h80000000, 0);
    directed("nan_x_1",     32'h7F800001, 32'h3F800000, 32'h7FC00000, 0);
`ifdef FP_MUL_ROUND_NEAREST_EN
    directed("tie",         32'h3F800001, 32'h3FC00000, 32'h3FC00002, 26);
`else
    directed("tie",         32'h3F800001, 32'h3FC00000, 32'h3FC00001, 26);
`endif

    // Start pulse mid-operation is ignored: exactly one result
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 32'h40000000; bus.multiplier = 32'h40400000;
    @(negedge clk);
    bus.start = 1'b0;
    vcount = 0;
    for (int i = 1; i < 40; i++) begin
      if (i == 10) begin
        bus.start = 1'b1; bus.multiplicand = 32'h3F800000; bus.multiplier = 32'h3F800000;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.valid) vcount++;
      @(negedge clk);
    end
    check("ignored_start_pulses", 32'(vcount), 32'd1);
    check("ignored_start_result", bus.out_reg, 32'h40C00000);

    // Reset mid-operation aborts with no result
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 32'h40000000; bus.multiplier = 32'h40400000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_valid", 32'(bus.valid), 32'd0);
    check("abort_out", bus.out_reg, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.valid) vcount++;
    end
    check("abort_no_valid", 32'(vcount), 32'd0);
    directed("after_abort", 32'h40000000, 32'h40400000, 32'h40C00000, 26);

    // Random traffic with sporadic starts
    repeat (5000) begin
      @(negedge clk);
      bus.start        = ($urandom_range(0, 5) == 0);
      bus.multiplicand = rand_op();
      bus.multiplier   = rand_op();
    end
    // start held high: re-triggers every IDLE cycle
    repeat (300) begin
      @(negedge clk);
      bus.start        = 1'b1;
      bus.multiplicand = rand_op();
      bus.multiplier   = rand_op();
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
